// File: rtl/cache_memory_bus.sv
// Arbitrates the instruction and data caches onto one AXI4 master port, moving
// whole 128-byte lines as 16-beat INCR bursts, and forwards ACE snoop invalidates.
module cache_memory_bus #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LINE_W     = DATA_WIDTH * 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              command_valid,
  input  logic [1:0]              command_store,
  input  logic [1:0]              command_rready,
  input  logic [2*ADDR_WIDTH-1:0] command_addr,
  input  logic [2*LINE_W-1:0]     data_in,
  output logic [1:0]              bus_valid,
  output logic [1:0]              bus_ready,
  output logic [LINE_W-1:0]       data_out,
  output logic                    invalidate,
  output logic [ADDR_WIDTH-1:0]   invalidate_addr,
  // write address channel
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // write response channel
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // read address channel
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // read data channel
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // ACE snoop address channel
  input  logic                    m_axi_acvalid,
  output logic                    m_axi_acready,
  input  logic [ADDR_WIDTH-1:0]   m_axi_acaddr,
  input  logic [3:0]              m_axi_acsnoop
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    k_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [LINE_W-1:0]       line_reg;
  logic [3:0]              beat_reg;
  logic                    grant_any;
  logic                    grant_idx;
  logic [ADDR_WIDTH-1:0]   grant_addr;
  logic [15:0]             beat_we;

  // Responses carry nothing we act on; IDs and resp codes are intentionally dropped.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp};

  // Data cache (index 0) wins whenever both clients request together.
  assign grant_any  = |command_valid;
  assign grant_idx  = ~command_valid[0];
  assign grant_addr = grant_idx ? command_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : command_addr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus_ready     = 2'b00;
    bus_valid     = 2'b00;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_reg)
      IDLE: begin
        bus_ready = 2'b11;
        if (grant_any) state_next = command_store[grant_idx] ? AW : AR;
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = R;
      end
      R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_next = DONE;
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = W;
      end
      W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && beat_reg == 4'd15) state_next = B;
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = DONE;
      end
      DONE: begin
        bus_valid = k_reg ? 2'b10 : 2'b01;
        if (command_rready[k_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg    <= 1'b0;
      addr_reg <= '0;
      line_reg <= '0;
      beat_reg <= 4'd0;
    end else begin
      if (state_reg == IDLE && grant_any) begin
        k_reg    <= grant_idx;
        addr_reg <= {grant_addr[ADDR_WIDTH-1:7], 7'b0};
        line_reg <= grant_idx ? data_in[2*LINE_W-1:LINE_W] : data_in[LINE_W-1:0];
        beat_reg <= 4'd0;
      end
      if (state_reg == R && m_axi_rvalid)
        beat_reg <= m_axi_rlast ? 4'd0 : beat_reg + 4'd1;
      if (state_reg == W && m_axi_wready)
        beat_reg <= beat_reg + 4'd1;
    end
  end

  // One write enable per beat slot of the returned line.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_beat_we
      assign beat_we[gi] = (state_reg == R) && m_axi_rvalid && (beat_reg == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (beat_we[i]) data_out[i*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
    end
  end

  // Snoop path runs regardless of the bus FSM; only MakeInvalid (0xD) is forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      invalidate      <= 1'b0;
      invalidate_addr <= '0;
    end else begin
      invalidate <= m_axi_acvalid && (m_axi_acsnoop == 4'hD);
      if (m_axi_acvalid && m_axi_acsnoop == 4'hD) invalidate_addr <= m_axi_acaddr;
    end
  end

  assign m_axi_acready = 1'b1;

  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, k_reg};
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = 8'd15;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = {k_reg, 2'b00};

  assign m_axi_awid    = {{(ID_WIDTH-1){1'b0}}, k_reg};
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = 8'd15;
  assign m_axi_awsize  = 3'd3;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = {k_reg, 2'b00};

  assign m_axi_wdata   = line_reg[DATA_WIDTH*beat_reg +: DATA_WIDTH];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_reg == W) && (beat_reg == 4'd15);

endmodule

// File: tb/tb_cache_memory_bus.sv
// Directed bench for cache_memory_bus: reads, arbitration, stores with wready
// back-pressure, AXI stalls, snoop invalidation and mid-burst reset.
module tb_cache_memory_bus;
  localparam int IDW = 13, AW = 64, DW = 64, SW = 8, LW = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      command_valid, command_store, command_rready;
  logic [2*AW-1:0] command_addr;
  logic [2*LW-1:0] data_in;
  logic [1:0]      bus_valid, bus_ready;
  logic [LW-1:0]   data_out;
  logic            invalidate;
  logic [AW-1:0]   invalidate_addr;
  logic [IDW-1:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr, m_axi_acaddr;
  logic [7:0]      m_axi_awlen, m_axi_arlen;
  logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]      m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic            m_axi_awlock, m_axi_arlock;
  logic [3:0]      m_axi_awcache, m_axi_arcache, m_axi_acsnoop;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready, m_axi_acvalid, m_axi_acready;

  int nvec = 0;
  int nerr = 0;
  logic [LW-1:0] exp_line;
  int wexp, cyc;
  logic tog;

  always #5 clk = ~clk;

  cache_memory_bus dut (
    .clk(clk), .reset(reset),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr), .data_in(data_in),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .data_out(data_out),
    .invalidate(invalidate), .invalidate_addr(invalidate_addr),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_acvalid(m_axi_acvalid), .m_axi_acready(m_axi_acready),
    .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Plays a 16-beat read burst (value base+i on beat i) with rvalid gaps;
  // optionally fires a MakeInvalid snoop alongside beat snoop_at.
  task automatic read_beats(input logic [63:0] base, input int snoop_at);
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 3) begin
        m_axi_rvalid  = 1'b0;
        m_axi_acvalid = 1'b0;
        @(negedge clk);
        chk("rready_gap", m_axi_rready, 1'b1);
      end
      m_axi_rvalid  = 1'b1;
      m_axi_rdata   = base + 64'(i);
      m_axi_rlast   = (i == 15);
      m_axi_acvalid = (i == snoop_at);
      m_axi_acsnoop = 4'hD;
      m_axi_acaddr  = 64'h8000_0040;
      @(negedge clk);
      if (i == snoop_at) begin
        chk("inv_pulse", invalidate, 1'b1);
        chk("inv_addr", invalidate_addr, 64'h8000_0040);
      end
      if (i == snoop_at + 1) chk("inv_drop", invalidate, 1'b0);
    end
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_acvalid = 1'b0;
  endtask

  function automatic logic [LW-1:0] line_of(input logic [63:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[64*i +: 64] = base + 64'(i);
    return l;
  endfunction

  initial begin
    reset = 1'b0;
    command_valid = 2'b00; command_store = 2'b00; command_rready = 2'b00;
    command_addr = '0; data_in = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_rid = '0; m_axi_rresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    m_axi_acvalid = 1'b0; m_axi_acaddr = '0; m_axi_acsnoop = 4'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_bus_valid", bus_valid, 2'b00);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_invalidate", invalidate, 1'b0);
    chk("rst_data_out", data_out, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_bus_ready", bus_ready, 2'b11);

    // client 0 read with arready stall
    command_addr[63:0] = 64'h1234_5678;
    command_valid = 2'b01;
    @(negedge clk);
    command_valid = 2'b00;
    chk("ar_valid", m_axi_arvalid, 1'b1);
    chk("ar_addr", m_axi_araddr, 64'h1234_5600);
    chk("ar_len", m_axi_arlen, 8'd15);
    chk("ar_size", m_axi_arsize, 3'd3);
    chk("ar_burst", m_axi_arburst, 2'b01);
    chk("ar_id", m_axi_arid, 13'd0);
    chk("busy_bus_ready", bus_ready, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_arvalid", m_axi_arvalid, 1'b1);
      chk("stall_araddr", m_axi_araddr, 64'h1234_5600);
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    chk("r_rready", m_axi_rready, 1'b1);
    chk("r_arvalid", m_axi_arvalid, 1'b0);
    read_beats(64'h0, -1);
    exp_line = line_of(64'h0);
    chk("rd0_bus_valid", bus_valid, 2'b01);
    chk("rd0_data", data_out, exp_line);
    repeat (2) begin
      @(negedge clk);
      chk("rd0_hold_valid", bus_valid, 2'b01);
      chk("rd0_hold_data", data_out, exp_line);
    end
    command_rready = 2'b01;
    @(negedge clk);
    command_rready = 2'b00;
    chk("rd0_ack_valid", bus_valid, 2'b00);
    chk("rd0_ack_ready", bus_ready, 2'b11);

    // both clients: data cache first, snoop during its burst
    command_addr[63:0]   = 64'h1000;
    command_addr[127:64] = 64'h20C4;
    command_valid = 2'b11;
    @(negedge clk);
    command_valid = 2'b10;
    chk("arb_first_id", m_axi_arid, 13'd0);
    chk("arb_first_addr", m_axi_araddr, 64'h1000);
    chk("arb_first_prot", m_axi_arprot, 3'b000);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    read_beats(64'h100, 6);
    chk("arb0_bus_valid", bus_valid, 2'b01);
    chk("arb0_bus_ready", bus_ready, 2'b00);
    chk("arb0_data", data_out, line_of(64'h100));
    command_rready = 2'b01;
    @(negedge clk);
    command_rready = 2'b00;
    chk("arb_idle_gap", bus_ready, 2'b11);
    @(negedge clk);
    command_valid = 2'b00;
    chk("arb_second_arvalid", m_axi_arvalid, 1'b1);
    chk("arb_second_id", m_axi_arid, 13'd1);
    chk("arb_second_prot", m_axi_arprot, 3'b100);
    chk("arb_second_addr", m_axi_araddr, 64'h2080);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    read_beats(64'h200, -1);
    chk("arb1_bus_valid", bus_valid, 2'b10);
    chk("arb1_data", data_out, line_of(64'h200));
    command_rready = 2'b10;
    @(negedge clk);
    command_rready = 2'b00;
    chk("arb1_ack_ready", bus_ready, 2'b11);

    // client 0 store with wready toggling
    command_addr[63:0] = 64'h4000_0010;
    for (int i = 0; i < 16; i++) data_in[64*i +: 64] = 64'hA0 + 64'(i);
    command_store = 2'b01;
    command_valid = 2'b01;
    @(negedge clk);
    command_valid = 2'b00;
    chk("aw_valid", m_axi_awvalid, 1'b1);
    chk("aw_addr", m_axi_awaddr, 64'h4000_0000);
    chk("aw_len", m_axi_awlen, 8'd15);
    chk("aw_id", m_axi_awid, 13'd0);
    chk("aw_no_ar", m_axi_arvalid, 1'b0);
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    wexp = 0; tog = 1'b0; cyc = 0;
    while (wexp < 16 && cyc < 100) begin
      chk("w_valid", m_axi_wvalid, 1'b1);
      chk("w_data", m_axi_wdata, 64'hA0 + 64'(wexp));
      chk("w_last", m_axi_wlast, wexp == 15);
      chk("w_strb", m_axi_wstrb, 8'hFF);
      m_axi_wready = tog;
      @(negedge clk);
      if (tog) wexp++;
      tog = ~tog;
      cyc++;
    end
    m_axi_wready = 1'b0;
    chk("b_bready", m_axi_bready, 1'b1);
    chk("b_wvalid", m_axi_wvalid, 1'b0);
    chk("b_bus_valid", bus_valid, 2'b00);
    m_axi_bvalid = 1'b1;
    @(negedge clk);
    m_axi_bvalid = 1'b0;
    chk("st_bus_valid", bus_valid, 2'b01);
    chk("st_bready_off", m_axi_bready, 1'b0);
    command_rready = 2'b01;
    @(negedge clk);
    command_rready = 2'b00;
    chk("st_ack_ready", bus_ready, 2'b11);

    // reset during W beat 7
    command_valid = 2'b01;
    @(negedge clk);
    command_valid = 2'b00;
    command_store = 2'b00;
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b1;
    repeat (7) @(negedge clk);
    chk("w7_data", m_axi_wdata, 64'hA7);
    reset = 1'b0;
    #1;
    chk("mid_rst_wvalid", m_axi_wvalid, 1'b0);
    chk("mid_rst_bus_ready", bus_ready, 2'b11);
    chk("mid_rst_data_out", data_out, '0);
    m_axi_wready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("post_rst_wvalid", m_axi_wvalid, 1'b0);
    chk("post_rst_bus_ready", bus_ready, 2'b11);

    // non-invalidate snoop is acknowledged and ignored
    m_axi_acvalid = 1'b1;
    m_axi_acsnoop = 4'h1;
    m_axi_acaddr  = 64'hDEAD_0000;
    chk("ac_ready", m_axi_acready, 1'b1);
    @(negedge clk);
    m_axi_acvalid = 1'b0;
    chk("other_snoop_ignored", invalidate, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
